// File: rtl/gcode_number_reader_pkg.sv
// rtl/gcode_number_reader_pkg.sv - shared constants and types for the G-code number reader
`timescale 1ns/1ps
package gcode_number_reader_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_DOT   = 8'h2E;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;

    // Reader FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_SCALE = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    // Where we are inside the literal
    typedef enum logic [1:0] {
        PH_SKIP = 2'd0,
        PH_SIGN = 2'd1,
        PH_INT  = 2'd2,
        PH_FRAC = 2'd3
    } num_phase_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CHAR_0) && (c <= CHAR_9);
    endfunction

endpackage

// File: rtl/gcode_number_reader_decimal_accumulator.sv
// rtl/gcode_number_reader_decimal_accumulator.sv - unsigned decimal accumulator with sticky overflow
//  clk, reset (async, active-low), clk_en : clocking
//  clear       : zero acc and ovf (highest priority)
//  push_digit  : acc = acc*10 + digit
//  mul10       : acc = acc*10
//  digit       : 0..9
//  mag         : low OUT_BITS of acc (valid when ovf=0)
//  ovf         : sticky, set when acc would exceed LIMIT
`timescale 1ns/1ps
module decimal_accumulator #(
    parameter int          ACC_BITS = 20,
    parameter int          OUT_BITS = 16,
    parameter int unsigned LIMIT    = 32767
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                clear,
    input  logic                push_digit,
    input  logic                mul10,
    input  logic [3:0]          digit,
    output logic [OUT_BITS-1:0] mag,
    output logic                ovf
);

    localparam logic [ACC_BITS-1:0] LIMIT_V = ACC_BITS'(LIMIT);

    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] times10;
    logic [ACC_BITS-1:0] next_acc;

    // acc never exceeds LIMIT while ovf=0, so the extra headroom bits
    // keep acc*10+9 from wrapping before the range check.
    always_comb begin
        times10  = (acc << 3) + (acc << 1);
        next_acc = push_digit ? (times10 + {{(ACC_BITS-4){1'b0}}, digit}) : times10;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clk_en) begin
            if (clear) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if ((push_digit || mul10) && !ovf) begin
                // Once overflowed, acc is frozen; result is discarded anyway.
                if (next_acc > LIMIT_V) begin
                    ovf <= 1'b1;
                end else begin
                    acc <= next_acc;
                end
            end
        end
    end

    assign mag = acc[OUT_BITS-1:0];

endmodule

// File: rtl/gcode_number_reader.sv
// rtl/gcode_number_reader.sv - converts one signed ASCII decimal literal from a byte FIFO to fixed point
//  clk, reset (async, active-low), clk_en     : clocking
//  trigger / rdy / done                       : upstream subparser handshake
//  char_in, rd_trigger, rd_rdy, rd_done,
//  is_empty                                   : byte FIFO pop interface
//  value, term_char, success                  : result, held until the next done
`timescale 1ns/1ps
module gcode_number_reader
    import gcode_number_reader_pkg::*;
#(
    parameter int VALUE_BITS  = 16,
    parameter int FRAC_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  trigger,
    output logic                  rdy,
    output logic                  done,
    input  logic [7:0]            char_in,
    output logic                  rd_trigger,
    input  logic                  rd_rdy,
    input  logic                  rd_done,
    input  logic                  is_empty,
    output logic [VALUE_BITS-1:0] value,
    output logic [7:0]            term_char,
    output logic                  success
);

    localparam int ACC_BITS = VALUE_BITS + 4;
    localparam int FC_BITS  = $clog2(FRAC_DIGITS + 2);
    localparam logic [FC_BITS-1:0] FD = FC_BITS'(FRAC_DIGITS);

    logic [2:0]            state;
    num_phase_e            phase;
    logic                  sign;
    logic                  digit_seen;
    logic [FC_BITS-1:0]    frac_cnt;
    logic [7:0]            char_q;
    logic [7:0]            term_q;

    logic                  acc_clear;
    logic                  acc_push;
    logic                  acc_mul10;
    logic [VALUE_BITS-1:0] mag;
    logic                  ovf;

    logic                  c_digit;
    logic                  c_space;
    logic                  c_sign;
    logic                  c_dot;
    logic                  frac_room;

    always_comb begin
        c_digit   = is_digit(char_q);
        c_space   = (char_q == CHAR_SPACE);
        c_sign    = (char_q == CHAR_MINUS) || (char_q == CHAR_PLUS);
        c_dot     = (char_q == CHAR_DOT);
        frac_room = (frac_cnt < FD);

        acc_clear = (state == ST_IDLE) && trigger;
        // Digits beyond FRAC_DIGITS are dropped: truncation, no rounding.
        acc_push  = (state == ST_EVAL) && c_digit && ((phase != PH_FRAC) || frac_room);
        acc_mul10 = (state == ST_SCALE) && frac_room;
    end

    decimal_accumulator #(
        .ACC_BITS (ACC_BITS),
        .OUT_BITS (VALUE_BITS),
        .LIMIT    ((2 ** (VALUE_BITS - 1)) - 1)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .clear      (acc_clear),
        .push_digit (acc_push),
        .mul10      (acc_mul10),
        .digit      (char_q[3:0]),
        .mag        (mag),
        .ovf        (ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            phase      <= PH_SKIP;
            sign       <= 1'b0;
            digit_seen <= 1'b0;
            frac_cnt   <= '0;
            char_q     <= '0;
            term_q     <= '0;
            rdy        <= 1'b1;
            done       <= 1'b0;
            rd_trigger <= 1'b0;
            value      <= '0;
            term_char  <= '0;
            success    <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (trigger) begin
                        rdy        <= 1'b0;
                        sign       <= 1'b0;
                        digit_seen <= 1'b0;
                        frac_cnt   <= '0;
                        phase      <= PH_SKIP;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd_rdy && !is_empty) begin
                        rd_trigger <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    rd_trigger <= 1'b0;
                    if (rd_done) begin
                        char_q <= char_in;
                        state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    state <= ST_REQ;
                    if (c_space && (phase == PH_SKIP)) begin
                        // leading blank, keep reading
                    end else if (c_sign && (phase == PH_SKIP)) begin
                        sign  <= (char_q == CHAR_MINUS);
                        phase <= PH_SIGN;
                    end else if (c_digit) begin
                        digit_seen <= 1'b1;
                        if (phase == PH_FRAC) begin
                            if (frac_room) begin
                                frac_cnt <= frac_cnt + FC_BITS'(1);
                            end
                        end else begin
                            phase <= PH_INT;
                        end
                    end else if (c_dot && (phase == PH_INT)) begin
                        phase <= PH_FRAC;
                    end else begin
                        term_q <= char_q;
                        state  <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    // Pad missing fractional digits so the result unit is fixed.
                    if (frac_room) begin
                        frac_cnt <= frac_cnt + FC_BITS'(1);
                    end else begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (digit_seen && !ovf) begin
                        value   <= sign ? (~mag + VALUE_BITS'(1)) : mag;
                        success <= 1'b1;
                    end else begin
                        value   <= '0;
                        success <= 1'b0;
                    end
                    term_char <= term_q;
                    done      <= 1'b1;
                    rdy       <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
